// File: rtl/pop_count_pipe.sv
// rtl/pop_count_pipe.sv - pipelined population count with running min/max statistics
// Leaf counts feed a binary adder tree; registers sit after every REG_EVERY levels.
module pop_count_pipe #(
  parameter int N         = 64,
  parameter int LEAF_W    = 4,
  parameter int REG_EVERY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               val_in,
  input  logic [N-1:0]       x,
  input  logic               stat_clr,
  output logic [$clog2(N):0] y,
  output logic               val_out,
  output logic [$clog2(N):0] y_min,
  output logic [$clog2(N):0] y_max,
  output logic               stat_val
);

  localparam int CW      = $clog2(N) + 1;
  localparam int NLEAF   = (N + LEAF_W - 1) / LEAF_W;
  localparam int D       = $clog2(NLEAF);
  localparam int NL      = 1 << D;
  localparam int PW      = NL * LEAF_W;
  localparam int SW      = $clog2(LEAF_W) + 1 + D;
  localparam int RDIV    = (REG_EVERY > 0) ? REG_EVERY : 1;
  localparam int LATENCY = (D == 0 || REG_EVERY == 0) ? 1 : 1 + (D + REG_EVERY - 1) / REG_EVERY;

  function automatic logic [SW-1:0] leaf_cnt(input logic [LEAF_W-1:0] b);
    leaf_cnt = '0;
    for (int j = 0; j < LEAF_W; j++) leaf_cnt = leaf_cnt + SW'(b[j]);
  endfunction

  // MSB zero padding so every leaf group is full width
  logic [PW-1:0] xp;
  always_comb begin
    xp = '0;
    xp[N-1:0] = x;
  end

  logic [SW-1:0] fin_c;
  logic [SW-1:0] fin_q;

  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int M    = NL >> k;
    localparam bit REGD = (k == 0) ? (REG_EVERY > 0 || D == 0)
                                   : (k == D || (REG_EVERY > 0 && (k % RDIV) == 0));
    logic [SW-1:0] cv [M];
    logic [SW-1:0] pv [M];

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < M; i++) begin : g_node
        assign cv[i] = leaf_cnt(xp[i*LEAF_W +: LEAF_W]);
      end
    end else begin : g_add
      for (genvar i = 0; i < M; i++) begin : g_node
        assign cv[i] = g_lvl[k-1].pv[2*i] + g_lvl[k-1].pv[2*i+1];
      end
    end

    if (REGD) begin : g_reg
      logic [SW-1:0] d_q [M];
      // only the last stage (y) needs a reset value; valid bits guard the rest
      always_ff @(posedge clk) begin
        if (rst && k == D) d_q <= '{default: '0};
        else if (en)       d_q <= cv;
      end
      assign pv = d_q;
    end else begin : g_comb
      assign pv = cv;
    end

    if (k == D) begin : g_fin
      assign fin_c = cv[0];
      assign fin_q = pv[0];
    end
  end

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  always_comb begin
    vld_d = vld_q;
    if (en) vld_d = (vld_q << 1) | LATENCY'(val_in);
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign y       = CW'(fin_q);
  assign val_out = vld_q[LATENCY-1];

  logic [CW-1:0] res;
  logic          res_vld;
  assign res     = CW'(fin_c);
  assign res_vld = en && vld_d[LATENCY-1];

  logic [CW-1:0] min_q, min_d, max_q, max_d;
  logic          sv_q, sv_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    sv_d  = sv_q;
    if (stat_clr) begin
      min_d = '0;
      max_d = '0;
      sv_d  = 1'b0;
    end else if (res_vld) begin
      if (!sv_q || res < min_q) min_d = res;
      if (!sv_q || res > max_q) max_d = res;
      sv_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
      sv_q  <= 1'b0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sv_q  <= sv_d;
    end
  end

  assign y_min    = min_q;
  assign y_max    = max_q;
  assign stat_val = sv_q;

endmodule
